// File: rtl/bp_mac_seq.sv
// bp_mac_seq -- sequencer for the shared backpropagation MAC.
//
// For each output row r it clears the MAC. It then issues N_CELL x N_GATE
// (dgate, weight) read addresses, with the gate index innermost. After the
// read pipeline drains, it writes the MAC result to delta-out address r.
//
// Optional feature: define BP_SEQ_PERF_EN to build the busy-cycle counter
// on o_perf_cycles. The counter is saturating and clears on start. When the
// macro is undefined, o_perf_cycles is tied to 0.
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   i_start           start pulse, accepted only in IDLE
//   i_abort           synchronous abort back to IDLE, with no write and no done
//   i_sel_layer       sampled at start, drives o_sel_wght for the whole run
//   o_busy, o_done    run status; o_done is a one-cycle completion pulse
//   o_sel_wght        latched layer select
//   o_sel_dgate       gate index of the term whose data reaches the MAC now
//   o_rd_addr_dgate   issued cell index c
//   o_wght_addr       issued weight address r*N_CELL + c
//   o_wght_gate       issued gate index g
//   o_rst_mac         MAC clear strobe
//   o_acc_mac         MAC accumulate enable
//   o_wr_dout         delta-out write strobe
//   o_wr_addr         delta-out write address (current row r)
//   o_perf_cycles     busy cycle count (0 unless BP_SEQ_PERF_EN)
//
// state  | meaning
// IDLE   | waiting for i_start
// CLR    | one cycle: clear the MAC, c = g = 0
// RUN    | issue one (c, g) term per cycle, N_CELL*N_GATE cycles
// DRAIN  | RD_LAT cycles: no issue, read pipeline empties into the MAC
// WRITE  | one cycle: write MAC result to row r
// DONE   | one cycle: completion pulse, then IDLE
module bp_mac_seq #(
    parameter int N_ROW    = 8,
    parameter int N_CELL   = 53,
    parameter int N_GATE   = 4,
    parameter int RD_LAT   = 1,
    parameter int ROW_AW   = 7,
    parameter int CELL_AW  = 9,
    parameter int WADDR_AW = 12
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_start,
    input  logic                i_abort,
    input  logic                i_sel_layer,
    output logic                o_busy,
    output logic                o_done,
    output logic                o_sel_wght,
    output logic [1:0]          o_sel_dgate,
    output logic [CELL_AW-1:0]  o_rd_addr_dgate,
    output logic [WADDR_AW-1:0] o_wght_addr,
    output logic [1:0]          o_wght_gate,
    output logic                o_rst_mac,
    output logic                o_acc_mac,
    output logic                o_wr_dout,
    output logic [ROW_AW-1:0]   o_wr_addr,
    output logic [15:0]         o_perf_cycles
);

    generate
        if (RD_LAT < 1 || RD_LAT > 3) begin : g_bad_lat
            $error("bp_mac_seq: RD_LAT must be in 1..3");
        end
        if (N_GATE < 1 || N_GATE > 4) begin : g_bad_gate
            $error("bp_mac_seq: N_GATE must be in 1..4");
        end
        if ((N_ROW - 1) * N_CELL + N_CELL - 1 >= (1 << WADDR_AW)) begin : g_bad_waddr
            $error("bp_mac_seq: WADDR_AW too narrow for N_ROW*N_CELL");
        end
        if (N_CELL - 1 >= (1 << CELL_AW)) begin : g_bad_caddr
            $error("bp_mac_seq: CELL_AW too narrow for N_CELL");
        end
        if (N_ROW - 1 >= (1 << ROW_AW)) begin : g_bad_raddr
            $error("bp_mac_seq: ROW_AW too narrow for N_ROW");
        end
    endgenerate

    localparam logic [1:0]         G_LAST     = 2'(N_GATE - 1);
    localparam logic [CELL_AW-1:0] C_LAST     = CELL_AW'(N_CELL - 1);
    localparam logic [ROW_AW-1:0]  R_LAST     = ROW_AW'(N_ROW - 1);
    localparam logic [1:0]         DRAIN_LOAD = 2'(RD_LAT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLR,
        S_RUN,
        S_DRAIN,
        S_WRITE,
        S_DONE
    } state_t;

    state_t                state;
    logic [ROW_AW-1:0]     r;
    logic [CELL_AW-1:0]    c;
    logic [1:0]            g;
    logic [WADDR_AW-1:0]   waddr;
    logic [1:0]            drain_cnt;
    logic [RD_LAT-1:0]     pipe_v;
    logic [1:0]            pipe_g [RD_LAT];
    logic                  issue;
    logic                  start_acc;

    assign issue     = (state == S_RUN);
    assign start_acc = (state == S_IDLE) && i_start && !i_abort;

    // The address outputs come straight from the term counters. waddr walks
    // r*N_CELL + c incrementally, so no multiplier is needed.
    assign o_rd_addr_dgate = c;
    assign o_wght_gate     = g;
    assign o_wght_addr     = waddr;
    assign o_wr_addr       = r;
    assign o_acc_mac       = pipe_v[RD_LAT-1];
    assign o_sel_dgate     = pipe_g[RD_LAT-1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            r          <= '0;
            c          <= '0;
            g          <= '0;
            waddr      <= '0;
            drain_cnt  <= '0;
            o_busy     <= 1'b0;
            o_done     <= 1'b0;
            o_sel_wght <= 1'b0;
            o_rst_mac  <= 1'b0;
            o_wr_dout  <= 1'b0;
        end else begin
            o_rst_mac <= 1'b0;
            o_wr_dout <= 1'b0;
            o_done    <= 1'b0;
            if (i_abort && state != S_IDLE) begin
                state     <= S_IDLE;
                o_busy    <= 1'b0;
                r         <= '0;
                c         <= '0;
                g         <= '0;
                waddr     <= '0;
                drain_cnt <= '0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (start_acc) begin
                            state      <= S_CLR;
                            o_sel_wght <= i_sel_layer;
                            o_busy     <= 1'b1;
                            o_rst_mac  <= 1'b1;
                        end
                    end
                    S_CLR: begin
                        state <= S_RUN;
                        c     <= '0;
                        g     <= '0;
                    end
                    S_RUN: begin
                        // The last term leaves c/g/waddr unchanged. DRAIN
                        // issues nothing, so their value there is unused.
                        if (g == G_LAST) begin
                            if (c == C_LAST) begin
                                state     <= S_DRAIN;
                                drain_cnt <= DRAIN_LOAD;
                            end else begin
                                g     <= '0;
                                c     <= c + 1'b1;
                                waddr <= waddr + 1'b1;
                            end
                        end else begin
                            g <= g + 1'b1;
                        end
                    end
                    S_DRAIN: begin
                        if (drain_cnt == 2'd0) begin
                            state     <= S_WRITE;
                            o_wr_dout <= 1'b1;
                        end else begin
                            drain_cnt <= drain_cnt - 1'b1;
                        end
                    end
                    S_WRITE: begin
                        if (r == R_LAST) begin
                            state  <= S_DONE;
                            o_done <= 1'b1;
                        end else begin
                            state     <= S_CLR;
                            o_rst_mac <= 1'b1;
                            r         <= r + 1'b1;
                            c         <= '0;
                            g         <= '0;
                            waddr     <= waddr + 1'b1;
                        end
                    end
                    S_DONE: begin
                        state  <= S_IDLE;
                        o_busy <= 1'b0;
                        r      <= '0;
                        c      <= '0;
                        g      <= '0;
                        waddr  <= '0;
                    end
                    default: begin
                        state  <= S_IDLE;
                        o_busy <= 1'b0;
                    end
                endcase
            end
        end
    end

    // Issue-valid and gate index are delayed by the read latency, so that
    // accumulate and gate select line up with the data reaching the MAC.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pipe_v <= '0;
            for (int i = 0; i < RD_LAT; i++) pipe_g[i] <= '0;
        end else if (i_abort) begin
            pipe_v <= '0;
            for (int i = 0; i < RD_LAT; i++) pipe_g[i] <= '0;
        end else begin
            for (int i = RD_LAT - 1; i > 0; i--) begin
                pipe_v[i] <= pipe_v[i-1];
                pipe_g[i] <= pipe_g[i-1];
            end
            pipe_v[0] <= issue;
            pipe_g[0] <= issue ? g : 2'd0;
        end
    end

`ifdef BP_SEQ_PERF_EN
    logic [15:0] perf_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_cnt <= '0;
        end else if (start_acc) begin
            perf_cnt <= '0;
        end else if (o_busy && perf_cnt != 16'hFFFF) begin
            perf_cnt <= perf_cnt + 16'd1;
        end
    end

    assign o_perf_cycles = perf_cnt;
`else
    assign o_perf_cycles = 16'd0;
`endif

endmodule

// File: tb/tb_bp_mac_seq.sv
`timescale 1ns/1ps
module tb_bp_mac_seq;
    localparam int N_ROW  = 2;
    localparam int N_CELL = 3;
    localparam int N_GATE = 4;
    localparam int T      = N_CELL * N_GATE;
    localparam int BIG    = 1 << 30;
    localparam logic [31:0] ONE_Q  = 32'h0100_0000;
    localparam logic [31:0] ROW_Q  = 32'h0C00_0000;

    logic clk = 1'b0;
    logic rst, i_start, i_abort, i_sel_layer;
    always #5 clk = ~clk;

    logic        busy [2];
    logic        done [2];
    logic        sel_wght [2];
    logic        rst_mac [2];
    logic        acc_mac [2];
    logic        wr_dout [2];
    logic [1:0]  sel_dgate [2];
    logic [1:0]  wght_gate [2];
    logic [8:0]  rd_addr [2];
    logic [11:0] wght_addr [2];
    logic [6:0]  wr_addr [2];
    logic [15:0] perf [2];

    bp_mac_seq #(.N_ROW(N_ROW), .N_CELL(N_CELL), .N_GATE(N_GATE), .RD_LAT(1)) dut_l1 (
        .clk(clk), .rst(rst), .i_start(i_start), .i_abort(i_abort), .i_sel_layer(i_sel_layer),
        .o_busy(busy[0]), .o_done(done[0]), .o_sel_wght(sel_wght[0]), .o_sel_dgate(sel_dgate[0]),
        .o_rd_addr_dgate(rd_addr[0]), .o_wght_addr(wght_addr[0]), .o_wght_gate(wght_gate[0]),
        .o_rst_mac(rst_mac[0]), .o_acc_mac(acc_mac[0]), .o_wr_dout(wr_dout[0]),
        .o_wr_addr(wr_addr[0]), .o_perf_cycles(perf[0])
    );

    bp_mac_seq #(.N_ROW(N_ROW), .N_CELL(N_CELL), .N_GATE(N_GATE), .RD_LAT(3)) dut_l3 (
        .clk(clk), .rst(rst), .i_start(i_start), .i_abort(i_abort), .i_sel_layer(i_sel_layer),
        .o_busy(busy[1]), .o_done(done[1]), .o_sel_wght(sel_wght[1]), .o_sel_dgate(sel_dgate[1]),
        .o_rd_addr_dgate(rd_addr[1]), .o_wght_addr(wght_addr[1]), .o_wght_gate(wght_gate[1]),
        .o_rst_mac(rst_mac[1]), .o_acc_mac(acc_mac[1]), .o_wr_dout(wr_dout[1]),
        .o_wr_addr(wr_addr[1]), .o_perf_cycles(perf[1])
    );

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Expected outputs in cycle k after start acceptance (k = 1 is CLR).
    typedef struct packed {
        bit busy; bit rst_mac; bit acc; bit wr; bit done; bit issue;
        int c; int g; int waddr; int sel_g; int wr_addr;
    } exp_t;

    function automatic exp_t model(input int k, input int lat);
        exp_t e;
        int p, row, j;
        e = '0;
        p = T + lat + 2;
        if (k < 1 || k > N_ROW * p + 1) return e;
        e.busy = 1'b1;
        if (k == N_ROW * p + 1) begin
            e.done = 1'b1;
            return e;
        end
        row = (k - 1) / p;
        j   = (k - 1) % p;
        e.rst_mac = (j == 0);
        if (j >= 1 && j <= T) begin
            e.issue = 1'b1;
            e.c     = (j - 1) / N_GATE;
            e.g     = (j - 1) % N_GATE;
            e.waddr = row * N_CELL + e.c;
        end
        if (j >= lat + 1 && j <= T + lat) begin
            e.acc   = 1'b1;
            e.sel_g = (j - 1 - lat) % N_GATE;
        end
        if (j == T + lat + 1) begin
            e.wr      = 1'b1;
            e.wr_addr = row;
        end
        return e;
    endfunction

    function automatic int lat_of(input int d);
        return (d == 0) ? 1 : 3;
    endfunction

    task automatic chk(input string name, input int d, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s [RD_LAT=%0d] cyc=%0d: got %0h, expected %0h", name, lat_of(d), cyc, act, exp);
        end
    endtask

    bit chk_on  = 1'b0;
    bit run_on  = 1'b0;
    bit exp_sel = 1'b0;
    int t0      = 0;
    int cut_k   = BIG;

    task automatic check_cycle(input int d);
        exp_t e;
        int k, lat, run_len, pexp;
        lat = lat_of(d);
        k   = cyc - t0;
        e   = (run_on && k <= cut_k) ? model(k, lat) : model(-1, lat);
        chk("busy",    d, busy[d],    e.busy);
        chk("rst_mac", d, rst_mac[d], e.rst_mac);
        chk("acc_mac", d, acc_mac[d], e.acc);
        chk("wr_dout", d, wr_dout[d], e.wr);
        chk("done",    d, done[d],    e.done);
        if (e.busy)  chk("sel_wght",  d, sel_wght[d],  exp_sel);
        if (e.issue) begin
            chk("rd_addr",   d, rd_addr[d],   e.c);
            chk("wght_addr", d, wght_addr[d], e.waddr);
            chk("wght_gate", d, wght_gate[d], e.g);
        end
        if (e.acc) chk("sel_dgate", d, sel_dgate[d], e.sel_g);
        if (e.wr)  chk("wr_addr",   d, wr_addr[d],   e.wr_addr);
`ifdef BP_SEQ_PERF_EN
        run_len = N_ROW * (T + lat + 2) + 1;
        if (run_on && k >= 1) begin
            pexp = k - 1;
            if (pexp > run_len) pexp = run_len;
            if (pexp > cut_k) pexp = cut_k;
            chk("perf", d, perf[d], pexp);
        end else if (!run_on) begin
            chk("perf", d, perf[d], 0);
        end
`else
        run_len = 0;
        pexp    = 0;
        chk("perf", d, perf[d], pexp + run_len);
`endif
    endtask

    // Event log and bench MAC: dgate = weight = 1.0 in Q8.24 for every term.
    longint mac [2];
    int rstm_cyc [2][8];
    int wr_cyc   [2][8];
    int wr_a     [2][8];
    longint wr_v [2][8];
    int n_rstm [2];
    int n_wr   [2];
    int n_acc  [2];
    int done_cyc [2];

    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (rst) mac[d] <= 0;
            else if (rst_mac[d]) mac[d] <= 0;
            else if (acc_mac[d]) mac[d] <= mac[d] + ((longint'(ONE_Q) * longint'(ONE_Q)) >>> 24);
        end
    end

    always @(negedge clk) begin
        if (chk_on) for (int d = 0; d < 2; d++) check_cycle(d);
        for (int d = 0; d < 2; d++) begin
            if (rst_mac[d] === 1'b1 && n_rstm[d] < 8) begin
                rstm_cyc[d][n_rstm[d]] = cyc;
                n_rstm[d]++;
            end
            if (wr_dout[d] === 1'b1 && n_wr[d] < 8) begin
                wr_cyc[d][n_wr[d]] = cyc;
                wr_a[d][n_wr[d]]   = int'(wr_addr[d]);
                wr_v[d][n_wr[d]]   = mac[d];
                n_wr[d]++;
            end
            if (acc_mac[d] === 1'b1) n_acc[d]++;
            if (done[d] === 1'b1) done_cyc[d] = cyc;
        end
    end

    task automatic clear_log();
        for (int d = 0; d < 2; d++) begin
            n_rstm[d] = 0; n_wr[d] = 0; n_acc[d] = 0; done_cyc[d] = -1;
            for (int i = 0; i < 8; i++) begin
                rstm_cyc[d][i] = -1; wr_cyc[d][i] = -1; wr_a[d][i] = -1; wr_v[d][i] = -1;
            end
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic begin_run(input bit sel);
        i_start     = 1'b1;
        i_sel_layer = sel;
        exp_sel     = sel;
        t0          = cyc;
        run_on      = 1'b1;
        cut_k       = BIG;
    endtask

    // Hand-computed timing pins, N_ROW=2, N_CELL=3:
    // RD_LAT=1 -> L=15, clears 1/16, writes 15/30, done 31.
    // RD_LAT=3 -> L=17, clears 1/18, writes 17/34, done 35.
    int lit_rstm [2][2] = '{'{1, 16}, '{1, 18}};
    int lit_wr   [2][2] = '{'{15, 30}, '{17, 34}};
    int lit_done [2]    = '{31, 35};

    task automatic check_literals(input int base);
        for (int d = 0; d < 2; d++) begin
            chk("n_rst_mac", d, n_rstm[d], 2);
            chk("n_wr",      d, n_wr[d],   2);
            chk("n_acc",     d, n_acc[d],  2 * T);
            chk("done_cyc",  d, done_cyc[d] - base, lit_done[d]);
            for (int i = 0; i < 2; i++) begin
                chk("rst_mac_cyc", d, rstm_cyc[d][i] - base, lit_rstm[d][i]);
                chk("wr_cyc",      d, wr_cyc[d][i] - base,   lit_wr[d][i]);
                chk("wr_addr_lit", d, wr_a[d][i], i);
                chk("wr_value",    d, wr_v[d][i], ROW_Q);
            end
`ifdef BP_SEQ_PERF_EN
            chk("perf_total", d, perf[d], lit_done[d]);
`else
            chk("perf_total", d, perf[d], 0);
`endif
        end
    endtask

    task automatic check_all_zero();
        for (int d = 0; d < 2; d++) begin
            chk("z_busy", d, busy[d], 0);       chk("z_done", d, done[d], 0);
            chk("z_sel_wght", d, sel_wght[d], 0); chk("z_rst_mac", d, rst_mac[d], 0);
            chk("z_acc", d, acc_mac[d], 0);     chk("z_wr", d, wr_dout[d], 0);
            chk("z_sel_dgate", d, sel_dgate[d], 0); chk("z_wght_gate", d, wght_gate[d], 0);
            chk("z_rd_addr", d, rd_addr[d], 0); chk("z_wght_addr", d, wght_addr[d], 0);
            chk("z_wr_addr", d, wr_addr[d], 0); chk("z_perf", d, perf[d], 0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: run still active at cyc=%0d, expected finish before 2000", cyc);
        $fatal(1);
    end

    initial begin
        int ta;
        rst = 1'b1; i_start = 1'b0; i_abort = 1'b0; i_sel_layer = 1'b0;
        clear_log();
        step(3);
        check_all_zero();
        rst = 1'b0;
        chk_on = 1'b1;
        step(2);

        // Basic two-row run, layer-1 weights.
        clear_log();
        begin_run(1'b1);
        step(1); i_start = 1'b0;
        step(40);
        check_literals(t0);

        // A second start while busy is ignored, and so is its layer select.
        clear_log();
        begin_run(1'b0);
        step(1); i_start = 1'b0;
        step(4);
        i_start = 1'b1; i_sel_layer = 1'b1;
        step(1); i_start = 1'b0;
        step(35);
        check_literals(t0);

        // Abort at k=10, then restart at k=12.
        clear_log();
        begin_run(1'b1);
        cut_k = 10;
        step(1); i_start = 1'b0;
        step(9);
        i_abort = 1'b1;
        step(1); i_abort = 1'b0;
        for (int d = 0; d < 2; d++) begin
            chk("abort_no_wr",   d, n_wr[d], 0);
            chk("abort_no_done", d, done_cyc[d], -1);
        end
        step(1);
        ta = t0;
        clear_log();
        begin_run(1'b0);
        step(1); i_start = 1'b0;
        step(40);
        check_literals(t0);
        chk("restart_done", 0, done_cyc[0] - ta, 43);
        chk("restart_done", 1, done_cyc[1] - ta, 47);

        // Start together with abort in IDLE does nothing.
        i_start = 1'b1; i_abort = 1'b1; i_sel_layer = 1'b1;
        step(1); i_start = 1'b0; i_abort = 1'b0;
        step(1);
        for (int d = 0; d < 2; d++) chk("start_abort_idle", d, busy[d], 0);
        step(3);

        // Asynchronous reset in the middle of row 1.
        clear_log();
        begin_run(1'b1);
        step(1); i_start = 1'b0;
        step(19);
        #1;
        run_on = 1'b0;
        rst = 1'b1;
        #1;
        check_all_zero();
        step(3);
        rst = 1'b0;
        step(20);
        for (int d = 0; d < 2; d++) begin
            chk("rst_one_write",  d, n_wr[d], 1);
            chk("rst_write_addr", d, wr_a[d][0], 0);
            chk("rst_no_done",    d, done_cyc[d], -1);
        end

        chk_on = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/bp_mac_seq.md
Name: bp_mac_seq

Overview:
- Sequencer for the shared backpropagation MAC that computes delta-out (dOut / dX) vectors from stored delta gates and transposed U/W weights.
- For each output row r it clears the MAC, streams N_CELL x N_GATE (dgate, weight) products through it, then writes the MAC result to the delta-out memory at address r.
- Drives the dgate mux select, weight select, memory read addresses, MAC control and the write strobe. Sits beside the delta/MAC datapath under the top-level training FSM.

Parameters:
- N_ROW, 8, output rows per run (cells of the destination layer).
- N_CELL, 53, source cells summed per row.
- N_GATE, 4, gates per cell (a, i, f, o); gate index is innermost.
- RD_LAT, 1, cycles from address issue to data valid at the MAC input (memory read latency); legal range 1..3.
- ROW_AW, 7, row/write-address width.
- CELL_AW, 9, dgate read-address width.
- WADDR_AW, 12, weight read-address width.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- i_start  in  1  start pulse; accepted only in IDLE.
- i_abort  in  1  synchronous abort; returns to IDLE next cycle.
- i_sel_layer  in  1  sampled at start; drives o_sel_wght for the whole run (1 = layer-1 U, 0 = layer-2 W/U).
- o_busy  out  1  high from the cycle after start acceptance until the DONE cycle inclusive.
- o_done  out  1  one-cycle pulse at run completion.
- o_sel_wght  out  1  registered copy of i_sel_layer.
- o_sel_dgate  out  2  gate index g of the term whose data reaches the MAC this cycle.
- o_rd_addr_dgate  out  CELL_AW  issued cell index c.
- o_wght_addr  out  WADDR_AW  issued weight address r*N_CELL + c.
- o_wght_gate  out  2  issued gate index g, used for the weight mux select.
- o_rst_mac  out  1  MAC clear strobe.
- o_acc_mac  out  1  MAC accumulate enable.
- o_wr_dout  out  1  delta-out memory write strobe.
- o_wr_addr  out  ROW_AW  delta-out write address (= r).
- o_perf_cycles  out  16  busy cycle count (optional feature).

Behaviour:
- Reset: all outputs 0, state IDLE, counters r/c/g = 0, valid pipeline cleared.
- FSM states: IDLE, CLR, RUN, DRAIN, WRITE, DONE.
- IDLE: i_start=1 latches i_sel_layer and moves to CLR. No other output activity.
- CLR (1 cycle): o_rst_mac=1; c=g=0; next state RUN.
- RUN (T = N_CELL*N_GATE cycles): each cycle issues the address for term (c, g). g increments each cycle and wraps 3->0, incrementing c. After the term c=N_CELL-1, g=N_GATE-1 the next state is DRAIN.
- Valid pipeline: a shift register of depth RD_LAT carries the issue-valid bit and g.
  - o_acc_mac = pipeline output valid.
  - o_sel_dgate = pipeline output g, aligned with the data arriving at the MAC.
- DRAIN (RD_LAT cycles): no new issues; the pipeline empties; the last o_acc_mac occurs in the final DRAIN cycle.
- WRITE (1 cycle): o_wr_dout=1, o_wr_addr=r; the MAC output is valid this cycle.
  - If r = N_ROW-1, next state is DONE.
  - Otherwise r increments and the next state is CLR.
- DONE (1 cycle): o_done=1, then IDLE with r=0.
- Per-row latency L = T + RD_LAT + 2 cycles. Run latency = N_ROW*L + 1 cycles from start acceptance to the o_done cycle.
- i_start while busy: ignored.
- i_abort (any non-IDLE state):
  - next state is IDLE and the pipeline is flushed;
  - no o_wr_dout and no o_done are produced;
  - o_rst_mac is not asserted.
- i_abort has priority over all state transitions. i_abort together with i_start in IDLE: the start is ignored.
- Asynchronous reset mid-run: immediate return to the reset values; no partial write.
- o_rst_mac, o_acc_mac and o_wr_dout are mutually exclusive in every cycle.
- Address widths must hold (N_ROW-1)*N_CELL + N_CELL-1; an elaboration-time check fails otherwise.

Optional Feature:
- Macro BP_SEQ_PERF_EN.
- Defined: o_perf_cycles clears on start acceptance, increments every busy cycle, saturates at 16'hFFFF, and holds its value in IDLE.
- Not defined: o_perf_cycles is tied to 0 and the counter logic is absent.

Test Plan:
- Setup: N_ROW=2, N_CELL=3, RD_LAT=1, start at cycle 0.
  - Expect o_rst_mac at cycles 1 and 16, 12 o_acc_mac cycles per row, o_wr_dout at cycle 15 (addr 0) and cycle 30 (addr 1), o_done at 31.
  - With BP_SEQ_PERF_EN, o_perf_cycles=31.
- Same config, MAC model with dgate=1.0 (Q8.24) and weight=1.0 for every term -> written values 12.0 (32'h0C000000) for both rows.
- Sweep RD_LAT=3 -> o_sel_dgate sequence 0,1,2,3 aligned 3 cycles after o_wght_gate. Per-row latency 17; o_done at cycle 35.
- i_start pulsed again at cycle 5 -> no effect; timing identical to the first test.
- i_abort at cycle 10 -> IDLE at cycle 11, no o_wr_dout, no o_done. A new start at cycle 12 completes normally with o_done at cycle 43.
- rst asserted asynchronously at cycle 20 -> all outputs 0 immediately; no write to address 1.
